// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding and
// the select codes understood by the shift core.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage

// File: rtl/tx_shift_core.sv
// N-bit shift register with hold, shift right, shift left and parallel load.
// Vacated positions fill with 0; both end bits are exposed for serial output.
module tx_shift_core
  import serial_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   i_sel,
  input  logic [N-1:0] i_d,
  output logic         o_msb,
  output logic         o_lsb
);

  logic [N-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      case (i_sel)
        SEL_SHR:  r_q <= {1'b0, r_q[N-1:1]};
        SEL_SHL:  r_q <= {r_q[N-2:0], 1'b0};
        SEL_LOAD: r_q <= i_d;
        default:  r_q <= r_q;
      endcase
    end
  end

  assign o_msb = r_q[N-1];
  assign o_lsb = r_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: accepts a word on valid/ready, emits it
// one bit per ser_en strobe, then waits GAP enabled cycles before the next word.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          LSB_FIRST = 1'b0,
  parameter int unsigned GAP       = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         ser_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         frame_start,
  output logic         busy
);

  localparam int unsigned      CW        = $clog2(N + 1);
  localparam logic [CW-1:0]    BIT_FULL  = CW'(N);
  localparam logic [3:0]       GAP_LAST  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
  localparam logic [1:0]       SEL_STEP  = LSB_FIRST ? SEL_SHR : SEL_SHL;
  // The parameter GAP shadows the state name, so the state is fully qualified.
  localparam tx_state_e        POST_SHIFT = (GAP == 0) ? IDLE : serial_pkg::GAP;

  tx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic          r_ser_valid, w_ser_valid_nxt;
  logic          r_frame_start, w_frame_start_nxt;
  logic [1:0]    w_sel;
  logic          w_msb, w_lsb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_ser_valid   <= w_ser_valid_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_ser_valid_nxt   = r_ser_valid;
    w_frame_start_nxt = r_frame_start;
    w_sel             = SEL_HOLD;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sel             = SEL_LOAD;
          w_state_nxt       = SHIFT;
          w_bit_cnt_nxt     = BIT_FULL;
          w_gap_cnt_nxt     = '0;
          w_ser_valid_nxt   = 1'b1;
          w_frame_start_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          w_sel             = SEL_STEP;
          w_bit_cnt_nxt     = r_bit_cnt - CW'(1);
          w_frame_start_nxt = 1'b0;
          if (r_bit_cnt == CW'(1)) begin
            w_ser_valid_nxt = 1'b0;
            w_state_nxt     = POST_SHIFT;
          end
        end
      end
      serial_pkg::GAP: begin
        if (ser_en) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  tx_shift_core #(.N(N)) u_core (
    .clk   (clk),
    .reset (reset),
    .i_sel (w_sel),
    .i_d   (in_data),
    .o_msb (w_msb),
    .o_lsb (w_lsb)
  );

  // The register drains to zero as it shifts, so the end bit is 0 outside a frame.
  assign ser_out     = LSB_FIRST ? w_lsb : w_msb;
  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);

endmodule
